// File: rtl/iq_integrate_dump.sv
// Integrate-and-dump matched filter: sums SPS matched I/Q samples per symbol, dumps scaled/saturated symbol.
// Latency: symbol strobe one cycle after the SPS-th accepted sample; data outputs hold between dumps.
// Backpressure: none; unmatched valids drop the sample and set a sticky mismatch flag.
//
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   I_tdata/I_tvalid          signed I sample stream
//   Q_tdata/Q_tvalid          signed Q sample stream
//   sym_align                 1-cycle pulse restarting the symbol boundary
//   I_sym_tdata/Q_sym_tdata   integrated, shifted and saturated symbol per rail
//   sym_tvalid                1-cycle strobe qualifying the symbol outputs
//   sym_bits                  {I_sym<0, Q_sym<0} hard decisions
//   sym_sat                   either rail clipped on this symbol
//   iq_mismatch               sticky: I_tvalid and Q_tvalid disagreed at some point
module iq_integrate_dump #(
   parameter int I_WIDTH   = 16,
   parameter int O_WIDTH   = 16,
   parameter int SPS       = 8,
   parameter int OUT_SHIFT = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [I_WIDTH-1:0] I_tdata,
   input  logic               I_tvalid,
   input  logic [I_WIDTH-1:0] Q_tdata,
   input  logic               Q_tvalid,
   input  logic               sym_align,
   output logic [O_WIDTH-1:0] I_sym_tdata,
   output logic [O_WIDTH-1:0] Q_sym_tdata,
   output logic               sym_tvalid,
   output logic [1:0]         sym_bits,
   output logic               sym_sat,
   output logic               iq_mismatch
);

   localparam int CNT_W = $clog2(SPS);
   localparam int ACC_W = I_WIDTH + CNT_W;
   // One bit wider than both the accumulator and the output so the clamp compares never wrap.
   localparam int SAT_W = ((ACC_W > O_WIDTH) ? ACC_W : O_WIDTH) + 1;

   localparam logic signed [SAT_W-1:0] SAT_MAX =
      {{(SAT_W-O_WIDTH+1){1'b0}}, {(O_WIDTH-1){1'b1}}};
   localparam logic signed [SAT_W-1:0] SAT_MIN = ~SAT_MAX;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SPS-1);

   typedef enum logic [0:0] {EMPTY = 1'b0, ACCUM = 1'b1} state_t;

   state_t                    state_q, state_d;
   logic        [CNT_W-1:0]   cnt_q, cnt_d;
   logic signed [ACC_W-1:0]   acc_i_q, acc_i_d;
   logic signed [ACC_W-1:0]   acc_q_q, acc_q_d;

   logic [O_WIDTH-1:0] i_sym_q, q_sym_q;
   logic               vld_q, sat_q, mism_q;
   logic [1:0]         bits_q;

   logic                    accept, mism;
   logic                    first, last, dump;
   logic signed [ACC_W-1:0] i_ext, q_ext, i_sum, q_sum;
   logic        [O_WIDTH:0] i_dump, q_dump;

   // Returns {clipped, value}: arithmetic shift then clamp to the output range.
   function automatic logic [O_WIDTH:0] scale_sat(input logic signed [ACC_W-1:0] sum);
      logic signed [ACC_W-1:0] sh;
      logic signed [SAT_W-1:0] ext;
      sh  = sum >>> OUT_SHIFT;
      ext = {{(SAT_W-ACC_W){sh[ACC_W-1]}}, sh};
      if (ext > SAT_MAX)      return {1'b1, SAT_MAX[O_WIDTH-1:0]};
      else if (ext < SAT_MIN) return {1'b1, SAT_MIN[O_WIDTH-1:0]};
      else                    return {1'b0, ext[O_WIDTH-1:0]};
   endfunction

   assign accept = I_tvalid & Q_tvalid;
   assign mism   = I_tvalid ^ Q_tvalid;

   // State register (with the datapath it sequences).
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= EMPTY;
         cnt_q   <= '0;
         acc_i_q <= '0;
         acc_q_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_i_q <= acc_i_d;
         acc_q_q <= acc_q_d;
      end
   end

   // Next-state logic: align always restarts, and beats a would-be completing sample.
   always_comb begin
      state_d = state_q;
      if (sym_align) begin
         state_d = accept ? ACCUM : EMPTY;
      end else if (accept) begin
         case (state_q)
            EMPTY:   state_d = ACCUM;
            ACCUM:   state_d = (cnt_q == LAST_CNT) ? EMPTY : ACCUM;
            default: state_d = EMPTY;
         endcase
      end
   end

   // Datapath / output-decode logic.
   always_comb begin
      i_ext  = {{(ACC_W-I_WIDTH){I_tdata[I_WIDTH-1]}}, I_tdata};
      q_ext  = {{(ACC_W-I_WIDTH){Q_tdata[I_WIDTH-1]}}, Q_tdata};
      i_sum  = acc_i_q + i_ext;
      q_sum  = acc_q_q + q_ext;
      i_dump = scale_sat(i_sum);
      q_dump = scale_sat(q_sum);
      // A sample opens a new symbol when nothing is pending or the boundary is being restarted.
      first  = sym_align || (state_q == EMPTY);
      last   = (state_q == ACCUM) && (cnt_q == LAST_CNT);
      dump   = accept && !first && last;

      cnt_d   = cnt_q;
      acc_i_d = acc_i_q;
      acc_q_d = acc_q_q;
      if (accept) begin
         if (first) begin
            acc_i_d = i_ext;
            acc_q_d = q_ext;
            cnt_d   = CNT_W'(1);
         end else if (last) begin
            acc_i_d = '0;
            acc_q_d = '0;
            cnt_d   = '0;
         end else begin
            acc_i_d = i_sum;
            acc_q_d = q_sum;
            cnt_d   = cnt_q + CNT_W'(1);
         end
      end else if (sym_align) begin
         acc_i_d = '0;
         acc_q_d = '0;
         cnt_d   = '0;
      end
   end

   // Registered symbol outputs; data holds until the next dump.
   always_ff @(posedge clk) begin
      if (rst) begin
         i_sym_q <= '0;
         q_sym_q <= '0;
         vld_q   <= 1'b0;
         sat_q   <= 1'b0;
         bits_q  <= '0;
         mism_q  <= 1'b0;
      end else begin
         vld_q  <= dump;
         mism_q <= mism_q | mism;
         if (dump) begin
            i_sym_q <= i_dump[O_WIDTH-1:0];
            q_sym_q <= q_dump[O_WIDTH-1:0];
            sat_q   <= i_dump[O_WIDTH] | q_dump[O_WIDTH];
            bits_q  <= {i_dump[O_WIDTH-1], q_dump[O_WIDTH-1]};
         end
      end
   end

   assign I_sym_tdata = i_sym_q;
   assign Q_sym_tdata = q_sym_q;
   assign sym_tvalid  = vld_q;
   assign sym_sat     = sat_q;
   assign sym_bits    = bits_q;
   assign iq_mismatch = mism_q;

endmodule

// File: tb/tb_iq_integrate_dump.sv
module tb_iq_integrate_dump;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] i_dat, q_dat;
   logic        i_vld, q_vld, align;

   logic [15:0] a_i, a_q, b_i, b_q;
   logic        a_vld, b_vld, a_sat, b_sat, a_mis, b_mis;
   logic [1:0]  a_bits, b_bits;

   always #5 clk = ~clk;

   // Two instances share the input stream: nominal scaling and unscaled (to exercise clipping).
   iq_integrate_dump #(.I_WIDTH(16), .O_WIDTH(16), .SPS(8), .OUT_SHIFT(3)) dut_a (
      .clk(clk), .rst(rst),
      .I_tdata(i_dat), .I_tvalid(i_vld), .Q_tdata(q_dat), .Q_tvalid(q_vld),
      .sym_align(align),
      .I_sym_tdata(a_i), .Q_sym_tdata(a_q), .sym_tvalid(a_vld),
      .sym_bits(a_bits), .sym_sat(a_sat), .iq_mismatch(a_mis));

   iq_integrate_dump #(.I_WIDTH(16), .O_WIDTH(16), .SPS(8), .OUT_SHIFT(0)) dut_b (
      .clk(clk), .rst(rst),
      .I_tdata(i_dat), .I_tvalid(i_vld), .Q_tdata(q_dat), .Q_tvalid(q_vld),
      .sym_align(align),
      .I_sym_tdata(b_i), .Q_sym_tdata(b_q), .sym_tvalid(b_vld),
      .sym_bits(b_bits), .sym_sat(b_sat), .iq_mismatch(b_mis));

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: the samples of the symbol in progress, plus expected outputs.
   int qi[$];
   int qq[$];
   int e_i[2], e_q[2], e_sat[2], e_bits[2];
   int e_vld, e_mis;

   function automatic int clampv(longint s, int sh, inout int sat);
      longint v;
      v = s >>> sh;
      if (v > 32767) begin sat = 1; return 32767; end
      if (v < -32768) begin sat = 1; return -32768; end
      return int'(v);
   endfunction

   task automatic check(string tag, logic signed [31:0] obs, logic signed [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_edge(bit iv, bit qv, int id, int qd, bit al, bit rs);
      longint si, sq;
      int     s;
      if (rs) begin
         qi.delete(); qq.delete();
         e_vld = 0; e_mis = 0;
         for (int k = 0; k < 2; k++) begin
            e_i[k] = 0; e_q[k] = 0; e_sat[k] = 0; e_bits[k] = 0;
         end
      end else begin
         e_vld = 0;
         if (iv != qv) e_mis = 1;
         if (al) begin qi.delete(); qq.delete(); end
         if (iv && qv) begin qi.push_back(id); qq.push_back(qd); end
         if (qi.size() == 8) begin
            si = 0; sq = 0;
            foreach (qi[n]) begin si += qi[n]; sq += qq[n]; end
            for (int k = 0; k < 2; k++) begin
               s = 0;
               e_i[k]    = clampv(si, (k == 0) ? 3 : 0, s);
               e_q[k]    = clampv(sq, (k == 0) ? 3 : 0, s);
               e_sat[k]  = s;
               e_bits[k] = ((e_i[k] < 0) ? 2 : 0) + ((e_q[k] < 0) ? 1 : 0);
            end
            e_vld = 1;
            qi.delete(); qq.delete();
         end
      end
   endtask

   // One clock: drive inputs, let the edge happen, update model, compare #1 after the edge.
   task automatic cyc(bit iv, bit qv, int id, int qd, bit al, bit rs);
      i_vld = iv; q_vld = qv; i_dat = 16'(id); q_dat = 16'(qd); align = al; rst = rs;
      @(posedge clk);
      model_edge(iv, qv, int'($signed(i_dat)), int'($signed(q_dat)), al, rs);
      #1;
      check("a_vld",  a_vld,  e_vld);
      check("b_vld",  b_vld,  e_vld);
      check("a_mis",  a_mis,  e_mis);
      check("b_mis",  b_mis,  e_mis);
      check("a_isym", $signed(a_i), e_i[0]);
      check("a_qsym", $signed(a_q), e_q[0]);
      check("a_bits", a_bits, e_bits[0]);
      check("a_sat",  a_sat,  e_sat[0]);
      check("b_isym", $signed(b_i), e_i[1]);
      check("b_qsym", $signed(b_q), e_q[1]);
      check("b_bits", b_bits, e_bits[1]);
      check("b_sat",  b_sat,  e_sat[1]);
   endtask

   task automatic idle(int n);
      for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0);
   endtask

   // n matched samples, each followed by 'gap' idle cycles.
   task automatic samples(int n, int id, int qd, int gap);
      for (int k = 0; k < n; k++) begin
         cyc(1, 1, id, qd, 0, 0);
         idle(gap);
      end
   endtask

   initial begin
      int r, id, qd;
      bit iv, qv, al, rs;

      i_vld = 0; q_vld = 0; i_dat = '0; q_dat = '0; align = 0; rst = 1;
      cyc(0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 1);
      idle(2);

      // Basic symbol, back-to-back samples.
      samples(8, 1000, -1000, 0);
      idle(3);
      // Same data, valid every third cycle.
      samples(8, 1000, -1000, 2);
      idle(3);
      // Full-scale inputs: clips only in the unscaled instance.
      samples(8, 32767, -32768, 0);
      idle(2);
      // Partial symbol discarded by align, then a fresh symbol.
      samples(5, 500, 300, 0);
      cyc(0, 0, 0, 0, 1, 0);
      samples(8, -200, 77, 0);
      idle(2);
      // Align concurrent with a sample: it becomes sample 1.
      samples(3, 123, -45, 0);
      cyc(1, 1, -321, 654, 1, 0);
      samples(7, -321, 654, 0);
      idle(2);
      // Align on what would have been the completing sample: no dump.
      samples(7, 4000, -4000, 0);
      cyc(1, 1, 111, 222, 1, 0);
      samples(7, 111, 222, 0);
      // Align right after a completing sample: registered strobe still appears.
      samples(8, -7, 9, 0);
      cyc(0, 0, 0, 0, 1, 0);
      idle(2);
      // Reset mid-symbol.
      samples(4, 9000, 9000, 0);
      cyc(0, 0, 0, 0, 0, 1);
      samples(8, 8, -8, 0);
      idle(2);
      // One-sided valid mid-symbol: dropped and flagged.
      samples(3, 60, -60, 0);
      cyc(1, 0, 5000, 5000, 0, 0);
      samples(5, 60, -60, 0);
      cyc(0, 1, 5000, 5000, 0, 0);
      idle(2);

      // Randomized traffic.
      for (int k = 0; k < 1500; k++) begin
         r  = $urandom_range(0, 99);
         iv = (r < 74);
         qv = (r < 70) || (r >= 74 && r < 78);
         al = ($urandom_range(0, 99) < 3);
         rs = ($urandom_range(0, 199) == 0);
         id = int'($urandom_range(0, 65535));
         qd = int'($urandom_range(0, 65535));
         if ($urandom_range(0, 3) == 0) begin
            id = ($urandom_range(0, 1) == 0) ? 32767 : 32768;
            qd = ($urandom_range(0, 1) == 0) ? 32767 : 32768;
         end
         cyc(iv, qv, id, qd, al, rs);
      end
      idle(3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
